// File: rtl/adc_pattern_source_if.sv
// Parallel ADC-style sample bus plus burst control for the pattern source.
// The source drives the bus (master); the capture side or bench drives start/mode (slave).
interface adc_pattern_source_if;
    logic       start;
    logic [1:0] mode;
    logic [9:0] adcDatabus;
    logic       adcValid;
    logic       busy;
    logic       done;

    modport master (
        input  start,
        input  mode,
        output adcDatabus,
        output adcValid,
        output busy,
        output done
    );

    modport slave (
        output start,
        output mode,
        input  adcDatabus,
        input  adcValid,
        input  busy,
        input  done
    );
endinterface

// File: rtl/adc_pattern_source.sv
// Stand-in for the 10-bit RF ADC: emits fixed-length bursts of midscale, ramp, triangle
// or LFSR samples through a PIPE_DEPTH register pipeline, all updates on the rising edge.
module adc_pattern_source #(
    parameter int          PIPE_DEPTH = 4,
    parameter int          BURST_LEN  = 1024,
    parameter int          RAMP_STEP  = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic                  clock,
    input logic                  reset,
    adc_pattern_source_if.master bus
);
    localparam int             CNT_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int             DRN_W       = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [9:0]     MIDSCALE    = 10'd512;
    localparam logic [9:0]     STEP        = 10'(RAMP_STEP);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(BURST_LEN - 1);
    localparam logic [DRN_W-1:0] LAST_DRAIN  = DRN_W'(PIPE_DEPTH - 1);

    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("adc_pattern_source: LFSR_SEED must be non-zero");
    end
    if (PIPE_DEPTH < 1 || BURST_LEN < 1) begin : g_bad_size
        $error("adc_pattern_source: PIPE_DEPTH and BURST_LEN must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       mode_reg, mode_next;
    logic [CNT_W-1:0] sample_count_reg, sample_count_next;
    logic [DRN_W-1:0] drain_count_reg, drain_count_next;
    logic [9:0]       ramp_reg, ramp_next;
    logic [9:0]       tri_reg, tri_next;
    logic             tri_up_reg, tri_up_next;
    logic [15:0]      lfsr_reg, lfsr_next;
    logic             done_reg, done_next;
    logic [9:0]       raw;
    logic             lfsr_fb;
    logic [9:0]       stage_in_data;
    logic             stage_in_valid;

    logic [9:0]       pipe_data_reg  [PIPE_DEPTH];
    logic             pipe_valid_reg [PIPE_DEPTH];

    // Taps 16,14,13,11 of x^16+x^14+x^13+x^11+1, shifting towards the MSB.
    assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_comb begin
        case (mode_reg)
            2'd0:    raw = MIDSCALE;
            2'd1:    raw = ramp_reg;
            2'd2:    raw = tri_reg;
            default: raw = lfsr_reg[15:6];
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            mode_reg         <= 2'd0;
            sample_count_reg <= '0;
            drain_count_reg  <= '0;
            ramp_reg         <= 10'd0;
            tri_reg          <= 10'd0;
            tri_up_reg       <= 1'b1;
            lfsr_reg         <= LFSR_SEED;
            done_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            mode_reg         <= mode_next;
            sample_count_reg <= sample_count_next;
            drain_count_reg  <= drain_count_next;
            ramp_reg         <= ramp_next;
            tri_reg          <= tri_next;
            tri_up_reg       <= tri_up_next;
            lfsr_reg         <= lfsr_next;
            done_reg         <= done_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        mode_next         = mode_reg;
        sample_count_next = sample_count_reg;
        drain_count_next  = drain_count_reg;
        ramp_next         = ramp_reg;
        tri_next          = tri_reg;
        tri_up_next       = tri_up_reg;
        lfsr_next         = lfsr_reg;
        done_next         = 1'b0;
        stage_in_data     = MIDSCALE;
        stage_in_valid    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    mode_next         = bus.mode;
                    ramp_next         = 10'd0;
                    tri_next          = 10'd0;
                    tri_up_next       = 1'b1;
                    lfsr_next         = LFSR_SEED;
                    sample_count_next = '0;
                    state_next        = RUN;
                end
            end
            RUN: begin
                stage_in_data  = raw;
                stage_in_valid = 1'b1;
                ramp_next      = ramp_reg + STEP;
                lfsr_next      = {lfsr_reg[14:0], lfsr_fb};
                // Endpoints are emitted once: turn around onto the neighbour value.
                if (tri_up_reg) begin
                    if (tri_reg == 10'd1023) begin
                        tri_next    = 10'd1022;
                        tri_up_next = 1'b0;
                    end else begin
                        tri_next = tri_reg + 10'd1;
                    end
                end else begin
                    if (tri_reg == 10'd0) begin
                        tri_next    = 10'd1;
                        tri_up_next = 1'b1;
                    end else begin
                        tri_next = tri_reg - 10'd1;
                    end
                end
                if (sample_count_reg == LAST_SAMPLE) begin
                    drain_count_next = '0;
                    state_next       = DRAIN;
                end else begin
                    sample_count_next = sample_count_reg + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_count_reg == LAST_DRAIN) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    drain_count_next = drain_count_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_data_reg[0]  <= MIDSCALE;
            pipe_valid_reg[0] <= 1'b0;
        end else begin
            pipe_data_reg[0]  <= stage_in_data;
            pipe_valid_reg[0] <= stage_in_valid;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < PIPE_DEPTH; gi++) begin : g_pipe
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    pipe_data_reg[gi]  <= MIDSCALE;
                    pipe_valid_reg[gi] <= 1'b0;
                end else begin
                    pipe_data_reg[gi]  <= pipe_data_reg[gi-1];
                    pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
                end
            end
        end
    endgenerate

    assign bus.adcDatabus = pipe_data_reg[PIPE_DEPTH-1];
    assign bus.adcValid   = pipe_valid_reg[PIPE_DEPTH-1];
    assign bus.busy       = (state_reg != IDLE);
    assign bus.done       = done_reg;
endmodule

// File: tb/tb_adc_pattern_source.sv
// Bench for adc_pattern_source: three parameterisations checked every cycle against a
// burst-timeline model, plus literal expectations for ramp, triangle, LFSR and reset.
module tb_adc_pattern_source;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_pattern_source_if if_a ();
    adc_pattern_source_if if_b ();
    adc_pattern_source_if if_c ();

    adc_pattern_source #(.PIPE_DEPTH(4), .BURST_LEN(8), .RAMP_STEP(300), .LFSR_SEED(16'hACE1))
        dut_a (.clock(clk), .reset(rst), .bus(if_a.master));
    adc_pattern_source #(.PIPE_DEPTH(1), .BURST_LEN(1), .RAMP_STEP(1), .LFSR_SEED(16'hACE1))
        dut_b (.clock(clk), .reset(rst), .bus(if_b.master));
    adc_pattern_source #(.PIPE_DEPTH(2), .BURST_LEN(2050), .RAMP_STEP(1), .LFSR_SEED(16'hACE1))
        dut_c (.clock(clk), .reset(rst), .bus(if_c.master));

    logic       st_in [3];
    logic [1:0] md_in [3];
    logic [9:0] obs_data  [3];
    logic       obs_valid [3];
    logic       obs_busy  [3];
    logic       obs_done  [3];

    assign if_a.start = st_in[0];
    assign if_b.start = st_in[1];
    assign if_c.start = st_in[2];
    assign if_a.mode  = md_in[0];
    assign if_b.mode  = md_in[1];
    assign if_c.mode  = md_in[2];
    assign obs_data[0] = if_a.adcDatabus;  assign obs_valid[0] = if_a.adcValid;
    assign obs_data[1] = if_b.adcDatabus;  assign obs_valid[1] = if_b.adcValid;
    assign obs_data[2] = if_c.adcDatabus;  assign obs_valid[2] = if_c.adcValid;
    assign obs_busy[0] = if_a.busy;  assign obs_done[0] = if_a.done;
    assign obs_busy[1] = if_b.busy;  assign obs_done[1] = if_b.done;
    assign obs_busy[2] = if_c.busy;  assign obs_done[2] = if_c.done;

    int pass_count  = 0;
    int total_count = 0;

    // Burst-timeline model: one accepted start edge per DUT, everything else derived from it.
    int        cyc = 0;
    bit        have_b [3];
    int        acc_e  [3];
    int        mode_l [3];
    bit [15:0] lfsr_tab [2050];

    bit cap_en_a = 0;
    bit cap_en_c = 0;
    bit hold_b   = 0;
    int cap_a [$];
    int cap_c [$];
    int vb_q  [$];

    function automatic int pd_of(int d);
        return (d == 0) ? 4 : (d == 1) ? 1 : 2;
    endfunction
    function automatic int bl_of(int d);
        return (d == 0) ? 8 : (d == 1) ? 1 : 2050;
    endfunction
    function automatic int step_of(int d);
        return (d == 0) ? 300 : 1;
    endfunction

    function automatic int gen(int mode, int k, int step);
        int m;
        case (mode)
            0: return 512;
            1: return (k * step) % 1024;
            2: begin
                m = k % 2046;
                return (m <= 1023) ? m : 2046 - m;
            end
            default: return int'(lfsr_tab[k][15:6]);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total_count++;
        if (act == exp) pass_count++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                have_b[d] = 0;
            end else if (st_in[d] &&
                         (!have_b[d] || cyc >= acc_e[d] + bl_of(d) + pd_of(d) + 1)) begin
                have_b[d] = 1;
                acc_e[d]  = cyc;
                mode_l[d] = int'(md_in[d]);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        for (int d = 0; d < 3; d++) begin
            int ed, ev, eb, edn, k, a, bl, pd;
            if (rst || !have_b[d]) begin
                ed = 512; ev = 0; eb = 0; edn = 0;
            end else begin
                a   = acc_e[d];
                bl  = bl_of(d);
                pd  = pd_of(d);
                k   = cyc - a - pd;
                ev  = (k >= 0 && k < bl) ? 1 : 0;
                ed  = (ev == 1) ? gen(mode_l[d], k, step_of(d)) : 512;
                eb  = (cyc >= a && cyc <= a + bl + pd - 1) ? 1 : 0;
                edn = (cyc == a + bl + pd) ? 1 : 0;
            end
            total_count++;
            if (int'(obs_data[d]) == ed && int'(obs_valid[d]) == ev &&
                int'(obs_busy[d]) == eb && int'(obs_done[d]) == edn) begin
                pass_count++;
            end else begin
                $display("FAIL cycle_check dut%0d cyc %0d: got data=%0d valid=%0b busy=%0b done=%0b, expected data=%0d valid=%0d busy=%0d done=%0d",
                         d, cyc, obs_data[d], obs_valid[d], obs_busy[d], obs_done[d], ed, ev, eb, edn);
            end
            if (obs_done[d] === 1'b1)
                $display("burst end: dut%0d mode %0d cycle %0d", d, mode_l[d], cyc);
        end
        if (cap_en_a && obs_valid[0]) cap_a.push_back(int'(obs_data[0]));
        if (cap_en_c && obs_valid[2] && cap_c.size() < 2050) cap_c.push_back(int'(obs_data[2]));
        if (hold_b && obs_valid[1]) vb_q.push_back(cyc);
    end

    initial begin
        int ramp_exp [8];
        lfsr_tab[0] = 16'hACE1;
        for (int i = 1; i < 2050; i++)
            lfsr_tab[i] = {lfsr_tab[i-1][14:0],
                           lfsr_tab[i-1][15] ^ lfsr_tab[i-1][13] ^ lfsr_tab[i-1][12] ^ lfsr_tab[i-1][10]};
        ramp_exp = '{0, 300, 600, 900, 176, 476, 776, 52};
        for (int d = 0; d < 3; d++) begin
            st_in[d] = 1'b0;
            md_in[d] = 2'd0;
        end
        rst = 1'b1;
        tick(3);
        chk("reset_bus", int'(obs_data[0]), 512);
        chk("reset_valid", int'(obs_valid[0]), 0);
        rst = 1'b0;

        // Ramp burst on A (mode changed mid-burst), triangle burst on C.
        cap_en_a = 1; cap_en_c = 1;
        st_in[0] = 1'b1; md_in[0] = 2'd1;
        st_in[2] = 1'b1; md_in[2] = 2'd2;
        tick(1);
        st_in[0] = 1'b0; md_in[0] = 2'd3;
        st_in[2] = 1'b0; md_in[2] = 2'd0;
        tick(20);
        cap_en_a = 0;
        chk("ramp_count", cap_a.size(), 8);
        for (int i = 0; i < 8 && i < cap_a.size(); i++) chk("ramp_sample", cap_a[i], ramp_exp[i]);

        // Two LFSR bursts on A must repeat the same sequence from the seed.
        cap_a.delete();
        cap_en_a = 1;
        repeat (2) begin
            st_in[0] = 1'b1; md_in[0] = 2'd3;
            tick(1);
            st_in[0] = 1'b0;
            tick(14);
        end
        cap_en_a = 0;
        chk("lfsr_count", cap_a.size(), 16);
        if (cap_a.size() == 16) begin
            chk("lfsr_first", cap_a[0], 32'h2B3);
            for (int i = 0; i < 8; i++) chk("lfsr_repeat", cap_a[i+8], cap_a[i]);
        end

        // Start held on B: one valid pulse every PIPE_DEPTH+2 = 3 cycles.
        hold_b = 1;
        for (int i = 0; i < 30; i++) begin
            st_in[1] = 1'b1;
            md_in[1] = 2'($urandom_range(0, 3));
            tick(1);
        end
        hold_b = 0;
        st_in[1] = 1'b0;
        chk("hold_pulses", (vb_q.size() >= 8) ? 1 : 0, 1);
        for (int i = 1; i < vb_q.size(); i++) chk("hold_spacing", vb_q[i] - vb_q[i-1], 3);

        // Random starts and mode changes on A and B while C finishes its long burst.
        for (int i = 0; i < 2100; i++) begin
            st_in[0] = ($urandom_range(0, 3) == 0);
            md_in[0] = 2'($urandom_range(0, 3));
            st_in[1] = ($urandom_range(0, 2) == 0);
            md_in[1] = 2'($urandom_range(0, 3));
            md_in[2] = 2'($urandom_range(0, 3));
            tick(1);
        end
        cap_en_c = 0;
        chk("tri_count", cap_c.size(), 2050);
        if (cap_c.size() == 2050) begin
            chk("tri_1022", cap_c[1022], 1022);
            chk("tri_1023", cap_c[1023], 1023);
            chk("tri_1024", cap_c[1024], 1022);
            chk("tri_1025", cap_c[1025], 1021);
            chk("tri_2046", cap_c[2046], 0);
            chk("tri_2047", cap_c[2047], 1);
        end
        for (int i = 0; i < 300; i++) begin
            for (int d = 0; d < 3; d++) begin
                st_in[d] = ($urandom_range(0, 4) == 0);
                md_in[d] = 2'($urandom_range(0, 3));
            end
            tick(1);
        end
        for (int d = 0; d < 3; d++) st_in[d] = 1'b0;
        tick(2100);

        // Reset in the middle of a ramp burst on A takes effect immediately.
        st_in[0] = 1'b1; md_in[0] = 2'd1;
        tick(1);
        st_in[0] = 1'b0;
        tick(5);
        chk("pre_reset_busy", int'(obs_busy[0]), 1);
        chk("pre_reset_valid", int'(obs_valid[0]), 1);
        rst = 1'b1;
        #1;
        chk("abort_bus", int'(obs_data[0]), 512);
        chk("abort_valid", int'(obs_valid[0]), 0);
        chk("abort_busy", int'(obs_busy[0]), 0);
        chk("abort_done", int'(obs_done[0]), 0);
        tick(2);
        rst = 1'b0;
        tick(20);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end
endmodule
